// File: rtl/histogram_scheduler.sv
// histogram_scheduler
//   Front-end scheduler for a histogram RAM. Two requesters (A, B) offer bin
//   values; a round-robin arbiter grants one at a time and forwards the value
//   to the histogram as a single storeData strobe, then leaves a gap so the
//   histogram's read-modify-write pipeline can finish. Once the configured
//   number of samples has been stored (or the host asks), the scheduler
//   starts a histogram readout and forwards the bin stream to the host.
//
// Ports
//   my_100MHz_clk, reset          : sole clock, synchronous active-high reset
//   reqA/dataA/ackA               : requester A (req held until ack)
//   reqB/dataB/ackB               : requester B
//   sampleTarget                  : samples per acquisition, 0 = no auto-trigger
//   readoutRequest                : host readout request pulse
//   storeData, dataValue          : sample strobe and bin value to histogram
//   startReadout                  : readout start strobe to histogram
//   readingOut, histogramValue    : readout window and bin count from histogram
//   binValid, binIndex, binCount  : registered readout stream to host
//   readoutDone, roError, busy    : completion pulse, timeout pulse, status
//
// All outputs are registered, so every strobe appears one cycle after the
// state decision that produced it (ack in STROBE, storeData in the first
// GAP cycle, startReadout in TRIGGER).

module histogram_scheduler #(
    parameter int spectrumWidth = 7,
    parameter int countWidth    = 16,
    parameter int roTimeout     = 8
) (
    input  logic                     my_100MHz_clk,
    input  logic                     reset,
    input  logic                     reqA,
    input  logic [spectrumWidth-1:0] dataA,
    output logic                     ackA,
    input  logic                     reqB,
    input  logic [spectrumWidth-1:0] dataB,
    output logic                     ackB,
    input  logic [countWidth-1:0]    sampleTarget,
    input  logic                     readoutRequest,
    output logic                     storeData,
    output logic [spectrumWidth-1:0] dataValue,
    output logic                     startReadout,
    input  logic                     readingOut,
    input  logic [spectrumWidth-1:0] histogramValue,
    output logic                     binValid,
    output logic [spectrumWidth-1:0] binIndex,
    output logic [spectrumWidth-1:0] binCount,
    output logic                     readoutDone,
    output logic                     roError,
    output logic                     busy
);

    localparam logic [2:0] ACCEPT  = 3'd0;
    localparam logic [2:0] STROBE  = 3'd1;
    localparam logic [2:0] GAP     = 3'd2;
    localparam logic [2:0] TRIGGER = 3'd3;
    localparam logic [2:0] WAIT_RO = 3'd4;
    localparam logic [2:0] DRAIN   = 3'd5;

    // Timer counts WAIT_RO cycles 0..roTimeout-1.
    localparam int timerWidth = (roTimeout > 1) ? $clog2(roTimeout) : 1;
    localparam logic [timerWidth-1:0] timerLast = timerWidth'(roTimeout - 1);

    // Three GAP cycles: gap counter runs 0,1,2.
    localparam logic [1:0] gapLast = 2'd2;

    logic [2:0]               state_r;
    logic [2:0]               stateNext_s;
    logic                     pending_r;
    logic                     pendingNext_s;
    logic [countWidth-1:0]    sampleCount_r;
    logic [countWidth-1:0]    sampleCountNext_s;
    logic [countWidth-1:0]    incCount_s;
    logic [spectrumWidth-1:0] beatCount_r;
    logic [spectrumWidth-1:0] beatCountNext_s;
    logic                     prioB_r;
    logic                     prioBNext_s;
    logic                     grantB_s;
    logic [1:0]               gapCount_r;
    logic [1:0]               gapCountNext_s;
    logic [timerWidth-1:0]    timer_r;
    logic [timerWidth-1:0]    timerNext_s;

    logic                     ackA_r;
    logic                     ackANext_s;
    logic                     ackB_r;
    logic                     ackBNext_s;
    logic                     storeData_r;
    logic                     storeDataNext_s;
    logic [spectrumWidth-1:0] dataValue_r;
    logic [spectrumWidth-1:0] dataValueNext_s;
    logic                     startReadout_r;
    logic                     startReadoutNext_s;
    logic                     binValid_r;
    logic                     binValidNext_s;
    logic [spectrumWidth-1:0] binIndex_r;
    logic [spectrumWidth-1:0] binIndexNext_s;
    logic [spectrumWidth-1:0] binCount_r;
    logic [spectrumWidth-1:0] binCountNext_s;
    logic                     readoutDone_r;
    logic                     readoutDoneNext_s;
    logic                     roError_r;
    logic                     roErrorNext_s;
    logic                     busy_r;

    // Arbitration and saturating sample-count increment.
    always_comb begin
        // B wins when alone, or on a tie when it holds priority.
        grantB_s = reqB & (~reqA | prioB_r);
        if (sampleCount_r == {countWidth{1'b1}}) begin
            incCount_s = sampleCount_r;
        end else begin
            incCount_s = sampleCount_r + countWidth'(1);
        end
    end

    // Next-state and next-output decode for the scheduler FSM.
    always_comb begin
        stateNext_s        = state_r;
        // A host request is remembered whatever the state.
        pendingNext_s      = pending_r | readoutRequest;
        sampleCountNext_s  = sampleCount_r;
        beatCountNext_s    = beatCount_r;
        prioBNext_s        = prioB_r;
        gapCountNext_s     = gapCount_r;
        timerNext_s        = timer_r;
        ackANext_s         = 1'b0;
        ackBNext_s         = 1'b0;
        storeDataNext_s    = 1'b0;
        dataValueNext_s    = dataValue_r;
        startReadoutNext_s = 1'b0;
        binValidNext_s     = 1'b0;
        binIndexNext_s     = binIndex_r;
        binCountNext_s     = binCount_r;
        readoutDoneNext_s  = 1'b0;
        roErrorNext_s      = 1'b0;

        case (state_r)
            ACCEPT: begin
                if (pending_r) begin
                    // Trigger beats requests; a request arriving this very
                    // cycle queues the following readout.
                    stateNext_s        = TRIGGER;
                    pendingNext_s      = readoutRequest;
                    startReadoutNext_s = 1'b1;
                end else if (reqA | reqB) begin
                    stateNext_s       = STROBE;
                    sampleCountNext_s = incCount_s;
                    prioBNext_s       = ~grantB_s;
                    if (grantB_s) begin
                        ackBNext_s      = 1'b1;
                        dataValueNext_s = dataB;
                    end else begin
                        ackANext_s      = 1'b1;
                        dataValueNext_s = dataA;
                    end
                    if ((sampleTarget != {countWidth{1'b0}}) && (incCount_s == sampleTarget)) begin
                        pendingNext_s = 1'b1;
                    end else begin
                        pendingNext_s = pending_r | readoutRequest;
                    end
                end else begin
                    stateNext_s = ACCEPT;
                end
            end
            STROBE: begin
                storeDataNext_s = 1'b1;
                gapCountNext_s  = 2'd0;
                stateNext_s     = GAP;
            end
            GAP: begin
                if (gapCount_r == gapLast) begin
                    gapCountNext_s = 2'd0;
                    stateNext_s    = ACCEPT;
                end else begin
                    gapCountNext_s = gapCount_r + 2'd1;
                end
            end
            TRIGGER: begin
                timerNext_s = {timerWidth{1'b0}};
                stateNext_s = WAIT_RO;
            end
            WAIT_RO: begin
                if (readingOut) begin
                    // The first readout beat is already on histogramValue.
                    binValidNext_s  = 1'b1;
                    binCountNext_s  = histogramValue;
                    binIndexNext_s  = beatCount_r;
                    beatCountNext_s = beatCount_r + spectrumWidth'(1);
                    stateNext_s     = DRAIN;
                end else if (timer_r == timerLast) begin
                    // Histogram never answered: abandon, keep sample count.
                    roErrorNext_s = 1'b1;
                    timerNext_s   = {timerWidth{1'b0}};
                    stateNext_s   = ACCEPT;
                end else begin
                    timerNext_s = timer_r + timerWidth'(1);
                end
            end
            DRAIN: begin
                if (readingOut) begin
                    binValidNext_s  = 1'b1;
                    binCountNext_s  = histogramValue;
                    binIndexNext_s  = beatCount_r;
                    beatCountNext_s = beatCount_r + spectrumWidth'(1);
                end else begin
                    readoutDoneNext_s = 1'b1;
                    sampleCountNext_s = {countWidth{1'b0}};
                    beatCountNext_s   = {spectrumWidth{1'b0}};
                    binIndexNext_s    = {spectrumWidth{1'b0}};
                    stateNext_s       = ACCEPT;
                end
            end
            default: begin
                stateNext_s = ACCEPT;
            end
        endcase
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge my_100MHz_clk) begin
        if (reset) begin
            state_r        <= ACCEPT;
            pending_r      <= 1'b0;
            sampleCount_r  <= {countWidth{1'b0}};
            beatCount_r    <= {spectrumWidth{1'b0}};
            prioB_r        <= 1'b0;
            gapCount_r     <= 2'd0;
            timer_r        <= {timerWidth{1'b0}};
            ackA_r         <= 1'b0;
            ackB_r         <= 1'b0;
            storeData_r    <= 1'b0;
            dataValue_r    <= {spectrumWidth{1'b0}};
            startReadout_r <= 1'b0;
            binValid_r     <= 1'b0;
            binIndex_r     <= {spectrumWidth{1'b0}};
            binCount_r     <= {spectrumWidth{1'b0}};
            readoutDone_r  <= 1'b0;
            roError_r      <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= stateNext_s;
            pending_r      <= pendingNext_s;
            sampleCount_r  <= sampleCountNext_s;
            beatCount_r    <= beatCountNext_s;
            prioB_r        <= prioBNext_s;
            gapCount_r     <= gapCountNext_s;
            timer_r        <= timerNext_s;
            ackA_r         <= ackANext_s;
            ackB_r         <= ackBNext_s;
            storeData_r    <= storeDataNext_s;
            dataValue_r    <= dataValueNext_s;
            startReadout_r <= startReadoutNext_s;
            binValid_r     <= binValidNext_s;
            binIndex_r     <= binIndexNext_s;
            binCount_r     <= binCountNext_s;
            readoutDone_r  <= readoutDoneNext_s;
            roError_r      <= roErrorNext_s;
            // busy mirrors the state being entered, so it tracks state_r.
            busy_r         <= (stateNext_s != ACCEPT);
        end
    end

    assign ackA         = ackA_r;
    assign ackB         = ackB_r;
    assign storeData    = storeData_r;
    assign dataValue    = dataValue_r;
    assign startReadout = startReadout_r;
    assign binValid     = binValid_r;
    assign binIndex     = binIndex_r;
    assign binCount     = binCount_r;
    assign readoutDone  = readoutDone_r;
    assign roError      = roError_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_histogram_scheduler.sv
// Directed bench for histogram_scheduler with a scoreboard of expected
// grants, stores and readout beats.
module tb_histogram_scheduler;
    localparam int SW = 7;
    localparam int CW = 16;
    localparam int RT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqA, reqB, ackA, ackB;
    logic [SW-1:0] dataA, dataB;
    logic [CW-1:0] sampleTarget;
    logic          readoutRequest, storeData, startReadout, readingOut;
    logic [SW-1:0] dataValue, histogramValue, binIndex, binCount;
    logic          binValid, readoutDone, roError, busy;

    always #5 clk = ~clk;

    histogram_scheduler #(.spectrumWidth(SW), .countWidth(CW), .roTimeout(RT)) dut (
        .my_100MHz_clk(clk), .reset(reset),
        .reqA(reqA), .dataA(dataA), .ackA(ackA),
        .reqB(reqB), .dataB(dataB), .ackB(ackB),
        .sampleTarget(sampleTarget), .readoutRequest(readoutRequest),
        .storeData(storeData), .dataValue(dataValue), .startReadout(startReadout),
        .readingOut(readingOut), .histogramValue(histogramValue),
        .binValid(binValid), .binIndex(binIndex), .binCount(binCount),
        .readoutDone(readoutDone), .roError(roError), .busy(busy)
    );

    typedef struct packed {
        logic          isB;
        logic [SW-1:0] data;
    } grant_t;

    grant_t        grantQ[$];
    logic [SW-1:0] storeQ[$];
    logic [2*SW-1:0] beatQ[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   lastAckCyc = -100;
    int   lastStartCyc = 0;
    int   lastDoneCyc = 0;
    int   lastErrCyc = 0;
    int   nAck = 0, nStart = 0, nDone = 0, nErr = 0;
    logic modelPrioB = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and score whatever the DUT produced.
    task automatic step();
        grant_t g;
        logic [2*SW-1:0] b;
        @(negedge clk);
        cyc++;
        if (ackA || ackB) begin
            nAck++;
            check("ack_both", 32'(ackA & ackB), 32'd0);
            check("ack_expected", 32'(grantQ.size() > 0), 32'd1);
            if (grantQ.size() > 0) begin
                g = grantQ.pop_front();
                check("ack_who", 32'(ackB), 32'(g.isB));
                storeQ.push_back(g.data);
            end
            check("ack_spacing", 32'((cyc - lastAckCyc) >= 5), 32'd1);
            lastAckCyc = cyc;
        end
        if (storeData) begin
            check("store_latency", 32'(cyc), 32'(lastAckCyc + 1));
            check("store_expected", 32'(storeQ.size() > 0), 32'd1);
            if (storeQ.size() > 0) begin
                check("store_data", 32'(dataValue), 32'(storeQ.pop_front()));
            end
        end
        if (binValid) begin
            check("beat_expected", 32'(beatQ.size() > 0), 32'd1);
            if (beatQ.size() > 0) begin
                b = beatQ.pop_front();
                check("bin_index", 32'(binIndex), 32'(b[2*SW-1:SW]));
                check("bin_count", 32'(binCount), 32'(b[SW-1:0]));
            end
        end
        if (startReadout) begin nStart++; lastStartCyc = cyc; end
        if (readoutDone)  begin nDone++;  lastDoneCyc = cyc;  end
        if (roError)      begin nErr++;   lastErrCyc = cyc;   end
    endtask

    function automatic int evCount(input int kind);
        case (kind)
            0: return nStart;
            1: return nDone;
            2: return nErr;
            default: return nAck;
        endcase
    endfunction

    task automatic waitEv(input int kind, input int budget, input string tag);
        int n0;
        int k;
        n0 = evCount(kind);
        k = 0;
        while (evCount(kind) == n0 && k < budget) begin step(); k++; end
        check(tag, 32'(evCount(kind) != n0), 32'd1);
    endtask

    task automatic grantOne(input logic isB, input logic [SW-1:0] data, input string tag);
        grant_t g;
        g.isB = isB;
        g.data = data;
        grantQ.push_back(g);
        modelPrioB = ~isB;
        if (isB) begin reqB = 1'b1; dataB = data; end
        else begin reqA = 1'b1; dataA = data; end
        waitEv(3, 40, tag);
        reqA = 1'b0;
        reqB = 1'b0;
    endtask

    task automatic tieGrants(input int n, input string tag);
        grant_t g;
        int n0;
        int k;
        for (int i = 0; i < n; i++) begin
            g.isB = modelPrioB;
            g.data = modelPrioB ? 7'd42 : 7'd21;
            grantQ.push_back(g);
            modelPrioB = ~modelPrioB;
        end
        reqA = 1'b1; reqB = 1'b1; dataA = 7'd21; dataB = 7'd42;
        n0 = nAck;
        k = 0;
        while ((nAck - n0) < n && k < 20 * n) begin step(); k++; end
        reqA = 1'b0;
        reqB = 1'b0;
        check(tag, 32'(nAck - n0), 32'(n));
        check("tie_queue_empty", 32'(grantQ.size()), 32'd0);
    endtask

    // Called at the negedge where startReadout was seen.
    task automatic readoutBurst(input int n, input int reqAt, input logic holdReq, input string tag);
        logic [SW-1:0] hv;
        step();
        reqA = holdReq;
        for (int i = 0; i < n; i++) begin
            hv = SW'(i * 5 + 3);
            readingOut = 1'b1;
            histogramValue = hv;
            beatQ.push_back({SW'(i), hv});
            readoutRequest = (i == reqAt);
            step();
            if (i == 1) check("busy_in_drain", 32'(busy), 32'd1);
        end
        readingOut = 1'b0;
        readoutRequest = 1'b0;
        reqA = 1'b0;
        waitEv(1, 5, tag);
        check("beats_drained", 32'(beatQ.size()), 32'd0);
    endtask

    initial begin
        int firstAck;
        int doneBefore;
        reset = 1'b1; reqA = 1'b0; reqB = 1'b0; dataA = '0; dataB = '0;
        sampleTarget = '0; readoutRequest = 1'b0; readingOut = 1'b0; histogramValue = '0;
        step(); step();
        check("reset_outputs", 32'({ackA, ackB, storeData, dataValue, startReadout, binValid,
                                    binIndex, binCount, readoutDone, roError, busy}), 32'd0);
        reset = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_start", 32'(startReadout), 32'd0);

        // Single requester, data 5, then back-to-back grant spacing.
        grantOne(1'b0, 7'd5, "grantA_first");
        firstAck = lastAckCyc;
        grantOne(1'b0, 7'd6, "grantA_second");
        check("grant_spacing_min", 32'(lastAckCyc - firstAck), 32'd5);

        // Both requesters held: strict alternation.
        tieGrants(4, "tie_four_grants");

        // Target below the current count: no auto-trigger.
        sampleTarget = 16'd3;
        grantOne(1'b1, 7'd11, "grantB_over_target");
        doneBefore = nStart;
        for (int i = 0; i < 12; i++) step();
        check("no_trigger_over_target", 32'(nStart), 32'(doneBefore));
        check("stores_done", 32'(storeQ.size()), 32'd0);

        // Host readout, full 128-beat stream, requester ignored meanwhile.
        readoutRequest = 1'b1;
        step();
        readoutRequest = 1'b0;
        waitEv(0, 10, "host_start");
        readoutBurst(128, -1, 1'b1, "done_after_128");
        check("index_cleared", 32'(binIndex), 32'd0);

        // Count restarted from zero: three samples hit target 3.
        grantOne(1'b0, 7'd1, "sample1");
        grantOne(1'b1, 7'd2, "sample2");
        grantOne(1'b0, 7'd3, "sample3");
        waitEv(0, 10, "auto_start");
        check("auto_start_timing", 32'(lastStartCyc - lastAckCyc), 32'd5);

        // Histogram never answers: timeout.
        doneBefore = nDone;
        reqB = 1'b1;
        dataB = 7'd9;
        waitEv(2, 20, "ro_error_seen");
        reqB = 1'b0;
        check("ro_error_delay", 32'((lastErrCyc - lastStartCyc) >= RT && (lastErrCyc - lastStartCyc) <= RT + 1), 32'd1);
        check("busy_after_error", 32'(busy), 32'd0);
        check("no_done_on_error", 32'(nDone), 32'(doneBefore));
        step();
        check("ro_error_one_cycle", 32'(roError), 32'd0);

        // Request during DRAIN queues an immediate second readout.
        readoutRequest = 1'b1;
        step();
        readoutRequest = 1'b0;
        waitEv(0, 10, "third_start");
        readoutBurst(6, 2, 1'b0, "done_short");
        waitEv(0, 3, "queued_start");
        check("queued_start_delay", 32'((lastStartCyc - lastDoneCyc) >= 1 && (lastStartCyc - lastDoneCyc) <= 2), 32'd1);
        readoutBurst(3, -1, 1'b0, "done_queued");

        // Reset while in STROBE.
        sampleTarget = '0;
        grantOne(1'b1, 7'd9, "grant_before_reset");
        reset = 1'b1;
        step();
        check("reset_mid_strobe", 32'({ackA, ackB, storeData, dataValue, startReadout, binValid,
                                       binIndex, binCount, readoutDone, roError, busy}), 32'd0);
        grantQ.delete();
        storeQ.delete();
        modelPrioB = 1'b0;
        lastAckCyc = -100;
        reset = 1'b0;
        step();
        check("post_reset_store", 32'(storeData), 32'd0);
        check("post_reset_start", 32'(startReadout), 32'd0);
        tieGrants(2, "tie_after_reset");
        for (int i = 0; i < 6; i++) step();
        check("final_stores_done", 32'(storeQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/histogram_scheduler.md
HISTOGRAM_SCHEDULER -- requirements
Module: histogram_scheduler

Interface
REQ-001 The block SHALL have parameter spectrumWidth, default 7, giving the bin/data width and matching the histogram's spectrumWidth.
REQ-002 The block SHALL have parameter countWidth, default 16, giving the sample-counter width.
REQ-003 The block SHALL have parameter roTimeout, default 8, giving the cycles allowed for readingOut to rise after startReadout.
REQ-004 my_100MHz_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 reqA  input  1  requester A has a sample; held until ackA.
REQ-007 dataA  input  spectrumWidth  requester A bin value.
REQ-008 ackA  output  1  one-cycle grant to A.
REQ-009 reqB, dataB, ackB  as REQ-006..008, for requester B.
REQ-010 sampleTarget  input  countWidth  samples per acquisition; 0 disables auto-trigger.
REQ-011 readoutRequest  input  1  host pulse requesting readout.
REQ-012 storeData  output  1  to histogram; one-cycle strobe per sample.
REQ-013 dataValue  output  spectrumWidth  to histogram; granted bin value.
REQ-014 startReadout  output  1  to histogram; one-cycle strobe.
REQ-015 readingOut  input  1  from histogram; high during readout.
REQ-016 histogramValue  input  spectrumWidth  from histogram; bin count during readout.
REQ-017 binValid, binIndex[spectrumWidth], binCount[spectrumWidth]  outputs  readout stream to host.
REQ-018 readoutDone, roError, busy  outputs  1 each  completion pulse, timeout pulse, not-accepting status.

Function
REQ-019 The FSM SHALL have states ACCEPT, STROBE, GAP, TRIGGER, WAIT_RO and DRAIN; busy SHALL be 1 in every state except ACCEPT.
REQ-020 In ACCEPT, a pending trigger SHALL take priority over requests: next state TRIGGER, with no ack issued that cycle.
REQ-021 In ACCEPT with no pending trigger, if any req is high the FSM SHALL grant one requester: ackX=1 for that cycle, dataValue<=dataX, sampleCount+1 (saturating at all-ones), next state STROBE.
REQ-022 Arbitration SHALL be round-robin: when both reqs are high, grant the one not granted last; after reset, A wins the first tie.
REQ-023 STROBE SHALL drive storeData=1 for exactly one cycle, with dataValue stable; next state GAP.
REQ-024 GAP SHALL hold storeData=0 for 3 cycles to cover the histogram's read-modify-write pipeline, then return to ACCEPT; minimum grant spacing is therefore 5 cycles.
REQ-025 Pending SHALL be set by readoutRequest in any state, or when sampleTarget!=0 and sampleCount==sampleTarget after an increment; it SHALL be cleared on entering TRIGGER.
REQ-026 TRIGGER SHALL drive startReadout=1 for one cycle, then go to WAIT_RO.
REQ-027 WAIT_RO SHALL go to DRAIN on readingOut=1; if readingOut stays low for roTimeout cycles, it SHALL pulse roError for 1 cycle and return to ACCEPT without clearing sampleCount.
REQ-028 In DRAIN, each cycle with readingOut=1 SHALL produce binValid=1, binCount=histogramValue and binIndex = number of prior beats this readout (starting at 0, wrapping mod 2^spectrumWidth), all registered with one cycle of latency.
REQ-029 On the first cycle of DRAIN with readingOut=0, the block SHALL pulse readoutDone for 1 cycle, clear sampleCount and binIndex, and return to ACCEPT.
REQ-030 readoutRequest during TRIGGER, WAIT_RO or DRAIN SHALL set pending, causing a further readout immediately after return to ACCEPT.
REQ-031 reqA and reqB SHALL be ignored, with no ack, outside ACCEPT.
REQ-032 Changing sampleTarget mid-acquisition SHALL take effect on the next comparison; if sampleCount already exceeds the new target, no auto-trigger SHALL occur until readout.

Reset
REQ-033 On reset=1 at a clock edge the block SHALL enter ACCEPT, clear pending, sampleCount, binIndex and the round-robin pointer (A priority), and drive all outputs to 0, including mid-strobe or mid-readout.
REQ-034 The block SHALL issue no storeData or startReadout in the first cycle after reset deasserts.

Verification
REQ-035 reqA held with dataA=5, target=0 -> ackA 1 cycle, storeData pulse 1 cycle later with dataValue=5, next ackA no sooner than 5 cycles after the first.
REQ-036 reqA and reqB both held for 4 grants -> grant order A,B,A,B.
REQ-037 target=3, three samples -> startReadout pulses after the 3rd GAP; readingOut high 128 cycles -> 128 binValid beats with binIndex 0..127, then readoutDone; sampleCount=0 afterwards.
REQ-038 readoutRequest pulse during DRAIN -> a second startReadout within 2 cycles of readoutDone.
REQ-039 startReadout issued with readingOut held 0 -> roError pulse at cycle roTimeout, busy=0 after, no readoutDone.
REQ-040 reset asserted during STROBE -> storeData=0 and all outputs 0 the next cycle; the next tie is won by A.
